uart: RTL and testbench
=======================

Name: uart

Overview:
- Full-duplex 8N1 UART serving as the serial peripheral of the MIPS CPU system.
- The data-memory/peripheral bus block writes the transmit byte on `UART_TXD` and strobes `TX_EN`.
- It reads received bytes from `UART_RXD` when `RX_EFF` is high, and acknowledges them with `RX_READ`.
- Runs entirely on `sysclk` (100 MHz nominal); the bus side may be a slower clock, so all control inputs are edge/level tolerant.

Parameters:
- `CLK_FREQ`, 100000000, `sysclk` frequency in Hz.
- `BAUD_RATE`, 9600, serial bit rate.
- `CLKS_PER_BIT`, `CLK_FREQ/BAUD_RATE` (integer floor, 10416), `sysclk` cycles per bit; overridable for fast simulation.

Ports:
- `sysclk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `UART_RX`  in  1  serial input line, idle high.
- `UART_TX`  out  1  serial output line, idle high.
- `UART_TXD`  in  8  byte to transmit.
- `TX_EN`  in  1  transmit request.
- `TX_STATUS`  out  1  1 = transmitter idle/ready, 0 = busy.
- `UART_RXD`  out  8  last correctly received byte.
- `RX_EFF`  out  1  1 = `UART_RXD` holds an unread byte.
- `RX_READ`  in  1  acknowledge; clears `RX_EFF`.

Behaviour:
- Reset (`reset`=0, asynchronous) forces:
  - `UART_TX`=1, `TX_STATUS`=1, `UART_RXD`=8'h00, `RX_EFF`=0.
  - Both state machines to IDLE, all counters to 0.
- Reset asserted mid-frame aborts the frame immediately; the line returns high.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- TX request detection:
  - `TX_EN` passes through a 2-flop synchronizer; a transmission starts on its rising edge.
  - A `TX_EN` level held high for many cycles starts exactly one frame.
  - `UART_TXD` is latched into the shift register on that edge; later changes to `UART_TXD` do not affect the frame in flight.
  - A rising edge while `TX_STATUS`=0 is ignored (no queueing).
- TX states: IDLE → START → DATA (8 bits, bit counter 0..7) → STOP → IDLE.
  - `TX_STATUS` goes 0 on the cycle after the accepted edge.
  - `TX_STATUS` returns to 1 when the stop bit period completes.
  - `UART_TX` is registered (glitch-free).
- RX input: `UART_RX` passes through a 2-flop synchronizer.
- RX states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling edge (high→low) enters START.
  - START: the line is resampled at `CLKS_PER_BIT/2`. If it is high, the frame is a glitch: return to IDLE with no output change.
  - DATA: each data bit is sampled at its mid-point (every `CLKS_PER_BIT` cycles after the start mid-point) and shifted in LSB first.
  - STOP: the stop bit is sampled at its mid-point.
    - If 1: `UART_RXD` <= the received byte and `RX_EFF` <= 1 on that cycle.
    - If 0 (framing error): the byte is discarded, `UART_RXD`/`RX_EFF` are unchanged, and the machine returns to IDLE after the line goes high.
- After a valid stop sample, RX returns to IDLE immediately so back-to-back frames are accepted.
- `RX_EFF` handling:
  - Cleared on any `sysclk` cycle where `RX_READ`=1.
  - A new valid byte overwrites `UART_RXD` even if `RX_EFF`=1 (overrun: the old byte is lost).
  - If set and `RX_READ` occur in the same cycle, set wins.
- TX and RX are fully independent; loopback (`UART_TX` tied to `UART_RX`) must work.

Decomposition:
- Package `uart_pkg`:
  - Default `CLKS_PER_BIT` constant.
  - State enum type shared by TX/RX (IDLE, START, DATA, STOP).
  - Data width constant 8.
- Top module `uart` instantiates two sub-modules, `uart_tx` and `uart_rx`. Each has its own bit-period counter; there is no shared baud generator.
- Synchronizer flops live inside each sub-module.

Test Plan:
- Reset: drive `reset`=0 for 100 cycles, then release → `UART_TX`=1, `TX_STATUS`=1, `RX_EFF`=0, `UART_RXD`=8'h00.
- TX 0x55 (`CLKS_PER_BIT`=16), `TX_EN` held high 50 cycles → exactly one frame on `UART_TX`: bit sequence 0,1,0,1,0,1,0,1,0,1, each 16 cycles; `TX_STATUS`=0 for 160 cycles, then 1; no second frame.
- TX busy: a second `TX_EN` edge with `UART_TXD`=0xCC issued 40 cycles into the 0x55 frame → ignored; the line carries only 0x55.
- RX 0xA3 driven as a valid 8N1 frame → `UART_RXD`=8'hA3 and `RX_EFF`=1 at the stop-bit mid-point; pulse `RX_READ` for 1 cycle → `RX_EFF`=0 and `UART_RXD` still 8'hA3.
- RX glitch and framing error:
  - A 4-cycle low pulse → no change to `UART_RXD`/`RX_EFF`.
  - Frame 0x3C with stop bit 0 → byte discarded, `RX_EFF` stays 0.
  - A following good 0x3C → accepted.
- Loopback with async reset: `UART_TX` tied to `UART_RX`, send 0xFF then 0x00 → `UART_RXD` reads 0xFF then 0x00. Assert `reset` mid-frame → `UART_TX`=1 and `TX_STATUS`=1 immediately, with no partial byte received.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and types for the 8N1 UART (transmitter,
//                receiver and top level).
//                  CLKS_PER_BIT_DEF : default sysclk cycles per serial bit
//                  DATA_W           : data bits per frame
//                  uart_state_e     : frame state shared by TX and RX
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 100000000 / 9600;  // 10416
    localparam int DATA_W           = 8;
    localparam int BIT_IDX_W        = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 serial receiver with mid-bit sampling and its own
//                bit-period counter.
//                  clk_i   : system clock
//                  rst_ni  : asynchronous active-low reset
//                  rx_i    : serial line, idle high (synchronized here)
//                  read_i  : acknowledge, clears valid_o
//                  data_o  : last byte received with a good stop bit
//                  valid_o : 1 = data_o holds an unread byte
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    input  logic              read_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    localparam int                   CNT_W          = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]     c_BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]     c_HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] c_BIT_IDX_LAST = BIT_IDX_W'(DATA_W - 1);

    // [0],[1] form the synchronizer, [2] holds the previous synced value
    logic [2:0]           rx_sync_q;
    logic                 w_rx;
    logic                 w_fall;

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_IDX_W-1:0] bit_q;
    logic [DATA_W-1:0]    shift_q;
    logic [DATA_W-1:0]    data_q;
    logic                 valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync_q <= '1;
        end else begin
            rx_sync_q <= {rx_sync_q[1:0], rx_i};
        end
    end

    assign w_rx   = rx_sync_q[1];
    assign w_fall = ~rx_sync_q[1] & rx_sync_q[2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // A valid stop sample below is assigned later and wins
            if (read_i) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (w_fall) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == c_HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        // High at the start mid-point means a glitch
                        state_q <= w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {w_rx, shift_q[DATA_W-1:1]};
                        if (bit_q == c_BIT_IDX_LAST) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q   <= '0;
                        // On a framing error the line is still low; IDLE only
                        // reacts to a falling edge, so it waits for the line
                        // to go high before a new frame can start.
                        state_q <= ST_IDLE;
                        if (w_rx) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule : uart_rx
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : 8N1 serial transmitter with its own bit-period counter.
//                  clk_i    : system clock
//                  rst_ni   : asynchronous active-low reset
//                  tx_en_i  : transmit request (synchronized, rising edge)
//                  data_i   : byte captured when a request is accepted
//                  tx_o     : registered serial line, idle high
//                  ready_o  : 1 = idle, 0 = frame in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tx_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              tx_o,
    output logic              ready_o
);

    localparam int                   CNT_W          = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]     c_BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] c_BIT_IDX_LAST = BIT_IDX_W'(DATA_W - 1);

    // [0],[1] form the synchronizer, [2] holds the previous synced value
    logic [2:0]           en_sync_q;
    logic                 w_en_rise;

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_IDX_W-1:0] bit_q;
    logic [DATA_W-1:0]    shift_q;
    logic                 tx_q;
    logic                 ready_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_sync_q <= '0;
        end else begin
            en_sync_q <= {en_sync_q[1:0], tx_en_i};
        end
    end

    // A held-high request produces exactly one edge, hence one frame
    assign w_en_rise = en_sync_q[1] & ~en_sync_q[2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    // Edges seen outside IDLE are dropped, not queued
                    if (w_en_rise) begin
                        shift_q <= data_i;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                        state_q <= ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == c_BIT_IDX_LAST) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            bit_q   <= bit_q + BIT_IDX_W'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[DATA_W-1:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == c_BIT_LAST) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_o    = tx_q;
    assign ready_o = ready_q;

endmodule : uart_tx
`default_nettype wire

// File: rtl/uart.sv
`default_nettype none
// ============================================================================
//  Module      : uart
//  Description : Full-duplex 8N1 UART peripheral; independent TX and RX.
//                  sysclk    : system clock
//                  reset     : asynchronous active-low reset
//                  UART_RX   : serial input, idle high
//                  UART_TX   : serial output, idle high
//                  UART_TXD  : byte to transmit
//                  TX_EN     : transmit request (rising edge)
//                  TX_STATUS : 1 = transmitter ready
//                  UART_RXD  : last received byte
//                  RX_EFF    : 1 = unread byte in UART_RXD
//                  RX_READ   : acknowledge, clears RX_EFF
//  Revision    : 1.0 - initial release
// ============================================================================
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              UART_RX,
    output logic              UART_TX,
    input  logic [DATA_W-1:0] UART_TXD,
    input  logic              TX_EN,
    output logic              TX_STATUS,
    output logic [DATA_W-1:0] UART_RXD,
    output logic              RX_EFF,
    input  logic              RX_READ
);

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk_i   (sysclk),
        .rst_ni  (reset),
        .tx_en_i (TX_EN),
        .data_i  (UART_TXD),
        .tx_o    (UART_TX),
        .ready_o (TX_STATUS)
    );

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i   (sysclk),
        .rst_ni  (reset),
        .rx_i    (UART_RX),
        .read_i  (RX_READ),
        .data_o  (UART_RXD),
        .valid_o (RX_EFF)
    );

endmodule : uart
`default_nettype wire

// File: tb/tb_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart
//  Description : Self-checking bench for the uart top level. Frames are
//                described as ten line levels (start, 8 data LSB first, stop)
//                and compared against the serial line or used to drive it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart;

    localparam int CPB = 16;

    logic       sysclk;
    logic       reset;
    logic       UART_RX;
    logic       UART_TX;
    logic [7:0] UART_TXD;
    logic       TX_EN;
    logic       TX_STATUS;
    logic [7:0] UART_RXD;
    logic       RX_EFF;
    logic       RX_READ;

    logic       rx_line;
    logic       loop_en;

    int checks;
    int errors;

    // receive-side model state
    logic [7:0] exp_rxd;
    logic       exp_eff;

    assign UART_RX = loop_en ? UART_TX : rx_line;

    uart #(
        .CLK_FREQ     (100000000),
        .BAUD_RATE    (9600),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .UART_TX   (UART_TX),
        .UART_TXD  (UART_TXD),
        .TX_EN     (TX_EN),
        .TX_STATUS (TX_STATUS),
        .UART_RXD  (UART_RXD),
        .RX_EFF    (RX_EFF),
        .RX_READ   (RX_READ)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    function automatic logic [9:0] frame_of(input logic [7:0] b, input logic stop);
        return {stop, b, 1'b0};
    endfunction

    // Waits for a start bit, then samples every bit at its centre.
    task automatic capture_frame(output logic [7:0] b, output logic ok);
        int n;
        ok = 1'b1;
        b  = 8'h00;
        n  = 0;
        while (UART_TX !== 1'b0 && n < 400) begin
            @(negedge sysclk);
            n++;
        end
        if (n >= 400) begin
            ok = 1'b0;
            return;
        end
        repeat (CPB / 2) @(negedge sysclk);
        if (UART_TX !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge sysclk);
            b[i] = UART_TX;
        end
        repeat (CPB) @(negedge sysclk);
        if (UART_TX !== 1'b1) ok = 1'b0;
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = frame_of(b, stop);
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            repeat (CPB) @(negedge sysclk);
        end
        rx_line = 1'b1;
    endtask

    task automatic pulse_read();
        RX_READ = 1'b1;
        @(negedge sysclk);
        RX_READ = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (100) @(negedge sysclk);
        checks += 4;
        if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_hold_tx: got %b want 1", UART_TX); end
        if (TX_STATUS !== 1'b1) begin errors++; $display("FAIL reset_hold_status: got %b want 1", TX_STATUS); end
        if (RX_EFF !== 1'b0) begin errors++; $display("FAIL reset_hold_eff: got %b want 0", RX_EFF); end
        if (UART_RXD !== 8'h00) begin errors++; $display("FAIL reset_hold_rxd: got %h want 00", UART_RXD); end
        reset = 1'b1;
        repeat (5) @(negedge sysclk);
        checks += 4;
        if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_rel_tx: got %b want 1", UART_TX); end
        if (TX_STATUS !== 1'b1) begin errors++; $display("FAIL reset_rel_status: got %b want 1", TX_STATUS); end
        if (RX_EFF !== 1'b0) begin errors++; $display("FAIL reset_rel_eff: got %b want 0", RX_EFF); end
        if (UART_RXD !== 8'h00) begin errors++; $display("FAIL reset_rel_rxd: got %h want 00", UART_RXD); end
        exp_rxd = 8'h00;
        exp_eff = 1'b0;
    endtask

    // 0x55 with TX_EN held for 50 cycles: checks the exact line waveform.
    task automatic test_tx_single();
        logic       tx_smp [0:10*CPB];
        logic       st_smp [0:10*CPB];
        logic [9:0] f;
        logic       found;
        int         wave_bad;
        int         stat_bad;
        int         extra;
        f        = frame_of(8'h55, 1'b1);
        found    = 1'b0;
        wave_bad = 0;
        stat_bad = 0;
        extra    = 0;
        fork
            begin
                UART_TXD = 8'h55;
                TX_EN    = 1'b1;
                repeat (50) @(negedge sysclk);
                TX_EN    = 1'b0;
            end
            begin
                for (int n = 0; n < 20 && !found; n++) begin
                    @(negedge sysclk);
                    if (UART_TX === 1'b0) found = 1'b1;
                end
                if (found) begin
                    for (int i = 0; i <= 10 * CPB; i++) begin
                        tx_smp[i] = UART_TX;
                        st_smp[i] = TX_STATUS;
                        @(negedge sysclk);
                    end
                end
            end
        join
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tx55_start: got no start bit want start within 20 cycles");
        end else begin
            for (int i = 0; i < 10 * CPB; i++) begin
                if (tx_smp[i] !== f[i / CPB]) wave_bad++;
                if (st_smp[i] !== 1'b0) stat_bad++;
            end
            checks += 4;
            if (wave_bad != 0) begin errors++; $display("FAIL tx55_wave: got %0d wrong line samples want 0", wave_bad); end
            if (stat_bad != 0) begin errors++; $display("FAIL tx55_busy: got %0d busy-window samples ready want 0", stat_bad); end
            if (st_smp[10*CPB] !== 1'b1) begin errors++; $display("FAIL tx55_ready: got %b want 1 after 160 cycles", st_smp[10*CPB]); end
            if (tx_smp[10*CPB] !== 1'b1) begin errors++; $display("FAIL tx55_idle: got %b want 1 after frame", tx_smp[10*CPB]); end
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL tx55_second: got %0d low samples want 0", extra); end
    endtask

    // Second request 40 cycles into a frame is dropped.
    task automatic test_tx_busy();
        logic [7:0] got;
        logic       ok;
        int         extra;
        extra = 0;
        fork
            begin
                UART_TXD = 8'h55;
                TX_EN    = 1'b1;
                repeat (5) @(negedge sysclk);
                TX_EN    = 1'b0;
                repeat (38) @(negedge sysclk);
                UART_TXD = 8'hCC;
                TX_EN    = 1'b1;
                repeat (5) @(negedge sysclk);
                TX_EN    = 1'b0;
            end
            capture_frame(got, ok);
        join
        checks += 2;
        if (!ok) begin errors++; $display("FAIL busy_frame: got bad framing want valid frame"); end
        if (got !== 8'h55) begin errors++; $display("FAIL busy_byte: got %h want 55", got); end
        for (int i = 0; i < 300; i++) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1) extra++;
        end
        checks += 2;
        if (extra != 0) begin errors++; $display("FAIL busy_queued: got %0d low samples want 0", extra); end
        if (TX_STATUS !== 1'b1) begin errors++; $display("FAIL busy_ready: got %b want 1", TX_STATUS); end
    endtask

    task automatic test_tx_random();
        logic [7:0] b;
        logic [7:0] got;
        logic       ok;
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            fork
                begin
                    UART_TXD = b;
                    TX_EN    = 1'b1;
                    repeat (3) @(negedge sysclk);
                    TX_EN    = 1'b0;
                    // bus data changing mid-frame must not matter
                    UART_TXD = ~b;
                end
                capture_frame(got, ok);
            join
            checks += 2;
            if (!ok) begin errors++; $display("FAIL txrand_frame[%0d]: got bad framing want valid frame", k); end
            if (got !== b) begin errors++; $display("FAIL txrand_byte[%0d]: got %h want %h", k, got, b); end
            for (int n = 0; n < 40 && TX_STATUS !== 1'b1; n++) @(negedge sysclk);
            repeat (2) @(negedge sysclk);
        end
    endtask

    task automatic test_rx_basic();
        logic [9:0] f;
        f = frame_of(8'hA3, 1'b1);
        for (int i = 0; i < 9; i++) begin
            rx_line = f[i];
            repeat (CPB) @(negedge sysclk);
        end
        checks++;
        if (RX_EFF !== 1'b0) begin errors++; $display("FAIL rxA3_early: got %b want 0 before stop", RX_EFF); end
        rx_line = 1'b1;
        repeat (CPB) @(negedge sysclk);
        exp_rxd = 8'hA3;
        exp_eff = 1'b1;
        checks += 2;
        if (RX_EFF !== exp_eff) begin errors++; $display("FAIL rxA3_eff: got %b want %b", RX_EFF, exp_eff); end
        if (UART_RXD !== exp_rxd) begin errors++; $display("FAIL rxA3_rxd: got %h want %h", UART_RXD, exp_rxd); end
        pulse_read();
        exp_eff = 1'b0;
        checks += 2;
        if (RX_EFF !== exp_eff) begin errors++; $display("FAIL rxA3_read_eff: got %b want %b", RX_EFF, exp_eff); end
        if (UART_RXD !== exp_rxd) begin errors++; $display("FAIL rxA3_read_rxd: got %h want %h", UART_RXD, exp_rxd); end
    endtask

    task automatic test_rx_glitch_ferr();
        rx_line = 1'b0;
        repeat (4) @(negedge sysclk);
        rx_line = 1'b1;
        repeat (12 * CPB) @(negedge sysclk);
        checks += 2;
        if (RX_EFF !== exp_eff) begin errors++; $display("FAIL glitch_eff: got %b want %b", RX_EFF, exp_eff); end
        if (UART_RXD !== exp_rxd) begin errors++; $display("FAIL glitch_rxd: got %h want %h", UART_RXD, exp_rxd); end
        drive_rx_frame(8'h3C, 1'b0);
        repeat (4) @(negedge sysclk);
        checks += 2;
        if (RX_EFF !== exp_eff) begin errors++; $display("FAIL ferr_eff: got %b want %b", RX_EFF, exp_eff); end
        if (UART_RXD !== exp_rxd) begin errors++; $display("FAIL ferr_rxd: got %h want %h", UART_RXD, exp_rxd); end
        drive_rx_frame(8'h3C, 1'b1);
        repeat (2) @(negedge sysclk);
        exp_rxd = 8'h3C;
        exp_eff = 1'b1;
        checks += 2;
        if (RX_EFF !== exp_eff) begin errors++; $display("FAIL good3C_eff: got %b want %b", RX_EFF, exp_eff); end
        if (UART_RXD !== exp_rxd) begin errors++; $display("FAIL good3C_rxd: got %h want %h", UART_RXD, exp_rxd); end
    endtask

    // Random bytes, occasional framing errors, reads skipped at random so
    // overruns occur; model: a good stop bit overwrites the byte.
    task automatic test_rx_random();
        logic [7:0] b;
        logic       stop;
        for (int k = 0; k < 10; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(3, 0) != 0);
            drive_rx_frame(b, stop);
            if (stop) begin
                exp_rxd = b;
                exp_eff = 1'b1;
            end
            repeat (2) @(negedge sysclk);
            checks += 2;
            if (RX_EFF !== exp_eff) begin errors++; $display("FAIL rxrand_eff[%0d]: got %b want %b", k, RX_EFF, exp_eff); end
            if (UART_RXD !== exp_rxd) begin errors++; $display("FAIL rxrand_rxd[%0d]: got %h want %h", k, UART_RXD, exp_rxd); end
            if ($urandom_range(1, 0) == 1) begin
                pulse_read();
                exp_eff = 1'b0;
                checks++;
                if (RX_EFF !== exp_eff) begin errors++; $display("FAIL rxrand_read[%0d]: got %b want %b", k, RX_EFF, exp_eff); end
            end
            repeat ($urandom_range(3, 0)) @(negedge sysclk);
        end
        pulse_read();
        exp_eff = 1'b0;
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [0:3];
        int         n;
        bytes[0] = 8'hFF;
        bytes[1] = 8'h00;
        bytes[2] = 8'($urandom);
        bytes[3] = 8'($urandom) | 8'h01;
        rx_line  = 1'b1;
        loop_en  = 1'b1;
        repeat (4) @(negedge sysclk);
        for (int k = 0; k < 4; k++) begin
            UART_TXD = bytes[k];
            TX_EN    = 1'b1;
            repeat (3) @(negedge sysclk);
            TX_EN    = 1'b0;
            n = 0;
            while (RX_EFF !== 1'b1 && n < 400) begin
                @(negedge sysclk);
                n++;
            end
            checks += 2;
            if (RX_EFF !== 1'b1) begin errors++; $display("FAIL loop_eff[%0d]: got %b want 1 within 400 cycles", k, RX_EFF); end
            if (UART_RXD !== bytes[k]) begin errors++; $display("FAIL loop_rxd[%0d]: got %h want %h", k, UART_RXD, bytes[k]); end
            pulse_read();
            for (int m = 0; m < 40 && TX_STATUS !== 1'b1; m++) @(negedge sysclk);
            repeat (2) @(negedge sysclk);
        end
        // reset in the middle of a looped-back frame
        UART_TXD = 8'h5A;
        TX_EN    = 1'b1;
        repeat (3) @(negedge sysclk);
        TX_EN    = 1'b0;
        repeat (60) @(negedge sysclk);
        reset = 1'b0;
        #1;
        checks += 4;
        if (UART_TX !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b want 1", UART_TX); end
        if (TX_STATUS !== 1'b1) begin errors++; $display("FAIL midrst_status: got %b want 1", TX_STATUS); end
        if (RX_EFF !== 1'b0) begin errors++; $display("FAIL midrst_eff: got %b want 0", RX_EFF); end
        if (UART_RXD !== 8'h00) begin errors++; $display("FAIL midrst_rxd: got %h want 00", UART_RXD); end
        repeat (5) @(negedge sysclk);
        reset = 1'b1;
        repeat (20 * CPB) @(negedge sysclk);
        checks += 3;
        if (RX_EFF !== 1'b0) begin errors++; $display("FAIL midrst_partial: got eff %b want 0", RX_EFF); end
        if (TX_STATUS !== 1'b1) begin errors++; $display("FAIL midrst_after_status: got %b want 1", TX_STATUS); end
        if (UART_TX !== 1'b1) begin errors++; $display("FAIL midrst_after_tx: got %b want 1", UART_TX); end
        loop_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        UART_TXD = 8'h00;
        TX_EN    = 1'b0;
        RX_READ  = 1'b0;
        rx_line  = 1'b1;
        loop_en  = 1'b0;
        exp_rxd  = 8'h00;
        exp_eff  = 1'b0;
        @(negedge sysclk);
        test_reset();
        test_tx_single();
        test_tx_busy();
        test_tx_random();
        test_rx_basic();
        test_rx_glitch_ferr();
        test_rx_random();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart
`default_nettype wire
